wb_commit_unit: RTL

Consumer end of the MEM/WB pipeline register: takes the W-stage bundle and commits it.
- Generates the registered register-file write port.
- Owns the HI/LO pair written by MULTU.
- Issues the PC redirect for J/JAL/JR.
- Runs a squash-shadow state machine that discards wrong-path instructions still in flight behind a taken jump.

---
 rtl/wb_commit_unit.sv | 113 +++++++++++
 1 files changed

// File: rtl/wb_commit_unit.sv
// Write-back commit stage: register-file write port, HI/LO, PC redirect,
// and the shadow that discards wrong-path instructions behind a taken jump.
module wb_commit_unit #(
    parameter int SHADOW = 3,
    parameter logic [4:0] RA_IDX = 5'd31
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_W,
    input  logic        multu_enW,
    input  logic        jr_selW,
    input  logic        dm2regW,
    input  logic        jumpW,
    input  logic        jal_selW,
    input  logic        we_regW,
    input  logic [1:0]  hilo_selW,
    input  logic [31:0] pc_plus_4W,
    input  logic [31:0] alu_paW,
    input  logic [63:0] alu_outW,
    input  logic [31:0] rd_dmW,
    input  logic [31:0] jtaW,
    input  logic [4:0]  rf_waW,
    input  logic [31:0] super_yW,
    output logic        rf_we,
    output logic [4:0]  rf_wa,
    output logic [31:0] rf_wd,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        squashing
);
    typedef enum logic {RUN, SQUASH} state_t;

    state_t      state_reg;
    logic [3:0]  cnt_reg;

    logic        live;
    logic [4:0]  wa_next;
    logic [31:0] wd_next;
    logic        jump_any;

    assign live     = valid_W && (state_reg == RUN);
    assign wa_next  = jal_selW ? RA_IDX : rf_waW;
    assign jump_any = jr_selW || jumpW;

    // hi/lo here are the pre-edge values, so MFLO right after MULTU sees the product
    always_comb begin
        wd_next = alu_outW[31:0];
        if (jal_selW)
            wd_next = pc_plus_4W;
        else if (hilo_selW == 2'b01)
            wd_next = lo;
        else if (hilo_selW == 2'b10)
            wd_next = hi;
        else if (hilo_selW == 2'b11)
            wd_next = super_yW;
        else if (dm2regW)
            wd_next = rd_dmW;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we       <= 1'b0;
            rf_wa       <= 5'd0;
            rf_wd       <= 32'd0;
            hi          <= 32'd0;
            lo          <= 32'd0;
            redirect    <= 1'b0;
            redirect_pc <= 32'd0;
            squashing   <= 1'b0;
            state_reg   <= RUN;
            cnt_reg     <= 4'd0;
        end else begin
            rf_we    <= live && (we_regW || jal_selW) && (wa_next != 5'd0);
            rf_wa    <= wa_next;
            rf_wd    <= wd_next;
            redirect <= live && jump_any;

            if (live && multu_enW) begin
                hi <= alu_outW[63:32];
                lo <= alu_outW[31:0];
            end

            if (live && jump_any)
                redirect_pc <= jr_selW ? alu_paW : jtaW;

            case (state_reg)
                RUN: begin
                    if (live && jump_any) begin
                        state_reg <= SQUASH;
                        cnt_reg   <= 4'(SHADOW);
                        squashing <= 1'b1;
                    end
                end
                SQUASH: begin
                    // bubbles do not consume shadow slots
                    if (valid_W) begin
                        cnt_reg <= cnt_reg - 4'd1;
                        if (cnt_reg == 4'd1) begin
                            state_reg <= RUN;
                            squashing <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_reg <= RUN;
                    squashing <= 1'b0;
                end
            endcase
        end
    end
endmodule
